// File: rtl/thee_clk_meas_sched.sv
// Round-robin clock measurement scheduler: grants one channel, settles 2 cycles, counts
// edge_pulse[sel] over WIN_CYCLES, then holds the result until it is accepted.
// Optional feature macro THEE_MEAS_SCHED_ABORT_EN: dropping req[sel] mid-window aborts it.
module thee_clk_meas_sched #(
    parameter int N_CH       = 4,
    parameter int WIN_CYCLES = 1024,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH-1:0]         edge_pulse,
    output logic [$clog2(N_CH)-1:0] sel,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(N_CH)-1:0] res_ch,
    output logic [CNT_W-1:0]        res_count,
    output logic                    res_ovf
);
    localparam int SW = $clog2(N_CH);
    localparam int TW = $clog2(WIN_CYCLES + 2);
    localparam logic [TW-1:0]    SETTLE_LAST = TW'(1);
    localparam logic [TW-1:0]    WIN_LAST    = TW'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [SW-1:0]    LAST_RST    = SW'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [TW-1:0]     timer_r;
    logic [CNT_W-1:0]  count_r;
    logic              ovf_r;
    logic [SW-1:0]     last_r;
    logic [SW-1:0]     sel_r;
    logic [SW-1:0]     res_ch_r;
    logic              busy_r;
    logic              valid_r;
    logic              busy_nx_s;
    logic              valid_nx_s;
    logic              gnt_found_s;
    logic [SW-1:0]     gnt_idx_s;
    logic [SW-1:0]     cand_s;
    logic              hit_s;
    logic              grant_s;
    logic              abort_s;

`ifdef THEE_MEAS_SCHED_ABORT_EN
    assign abort_s = ~req[sel_r];
`else
    assign abort_s = 1'b0;
`endif

    // Round-robin search starting one past the last served channel
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            cand_s      = SW'((int'(last_r) + i) % N_CH);
            hit_s       = ~gnt_found_s & req[cand_s];
            gnt_idx_s   = hit_s ? cand_s : gnt_idx_s;
            gnt_found_s = gnt_found_s | hit_s;
        end
    end

    assign grant_s = (state_r == IDLE) && gnt_found_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = gnt_found_s ? SETTLE : IDLE;
            SETTLE:  state_nx_s = abort_s ? IDLE : ((timer_r == SETTLE_LAST) ? MEASURE : SETTLE);
            MEASURE: state_nx_s = abort_s ? IDLE : ((timer_r == WIN_LAST) ? REPORT : MEASURE);
            REPORT:  state_nx_s = res_ready ? IDLE : REPORT;
            default: state_nx_s = IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below
    always_comb begin
        busy_nx_s  = (state_nx_s != IDLE);
        valid_nx_s = (state_nx_s == REPORT);
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            busy_r  <= busy_nx_s;
            valid_r <= valid_nx_s;
        end
    end

    // Phase timer: restarts on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= '0;
        end else if (state_nx_s != state_r) begin
            timer_r <= '0;
        end else if (state_r == SETTLE || state_r == MEASURE) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    // Grant bookkeeping; last_r moves on any return to IDLE (handshake or abort)
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r    <= '0;
            last_r   <= LAST_RST;
            res_ch_r <= '0;
        end else begin
            if (grant_s) begin
                sel_r <= gnt_idx_s;
            end
            if (state_r != IDLE && state_nx_s == IDLE) begin
                last_r <= sel_r;
            end
            if (state_r == MEASURE && state_nx_s == REPORT) begin
                res_ch_r <= sel_r;
            end
        end
    end

    // Saturating edge counter; SETTLE entry clears it so settle-time pulses never count
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else if (grant_s) begin
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else if (state_r == MEASURE && edge_pulse[sel_r]) begin
            if (count_r == CNT_MAX) begin
                ovf_r <= 1'b1;
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end
    end

    assign sel       = sel_r;
    assign busy      = busy_r;
    assign res_valid = valid_r;
    assign res_ch    = res_ch_r;
    assign res_count = count_r;
    assign res_ovf   = ovf_r;

endmodule

// File: doc/thee_clk_meas_sched.md
THEE_CLK_MEAS_SCHED -- requirements
Module: thee_clk_meas_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of monitored clock channels, legal range 2..16.
REQ-002 SHALL have parameter WIN_CYCLES, default 1024: measurement window length in clk cycles, legal range >= 1.
REQ-003 SHALL have parameter CNT_W, default 16: edge-count result width.
REQ-004 SHALL have port clk, input, 1: sole clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port req, input, N_CH: per-channel level request for a measurement.
REQ-007 SHALL have port edge_pulse, input, N_CH: one-clk pulse per rising edge of each monitored clock, already synchronized to clk.
REQ-008 SHALL have port sel, output, $clog2(N_CH): currently granted channel.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port res_valid, output, 1: result available.
REQ-011 SHALL have port res_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port res_ch, output, $clog2(N_CH): channel that the result belongs to.
REQ-013 SHALL have port res_count, output, CNT_W: edges counted in the window.
REQ-014 SHALL have port res_ovf, output, 1: count saturated.

Function
REQ-015 SHALL implement the FSM states IDLE, SETTLE, MEASURE and REPORT.
REQ-016 IDLE: with any req bit high, SHALL grant round-robin, searching from (last_grant+1) mod N_CH upward; SHALL latch sel and go to SETTLE on the next edge.
REQ-017 SETTLE: SHALL last exactly 2 cycles; edge_pulse is ignored; afterwards SHALL go to MEASURE.
REQ-018 MEASURE: SHALL last exactly WIN_CYCLES cycles; the count SHALL increment by 1 in each cycle where edge_pulse[sel]=1, including the first and last cycles.
REQ-019 The count SHALL saturate at 2^CNT_W-1; res_ovf SHALL be set when an increment is attempted at that value.
REQ-020 After the last MEASURE cycle, SHALL go to REPORT and assert res_valid with res_ch=sel, res_count and res_ovf stable.
REQ-021 REPORT: SHALL hold res_valid and the data until a cycle with res_ready=1; on that edge, res_valid SHALL drop, last_grant SHALL become sel, and the FSM SHALL return to IDLE.
REQ-022 A grant SHALL be issued no earlier than the cycle after the transaction's handshake completes, so back-to-back requests lose 1 IDLE cycle.
REQ-023 Total latency from grant to res_valid SHALL be 2+WIN_CYCLES cycles.
REQ-024 req changes outside IDLE SHALL not alter sel.
REQ-025 edge_pulse bits of non-selected channels SHALL be ignored.
REQ-026 The count and res_ovf SHALL clear on entry to SETTLE.

Reset
REQ-027 rst=1 at a clk edge SHALL force IDLE, with res_valid=0, busy=0, sel=0, res_ch=0, res_count=0, res_ovf=0, and last_grant=N_CH-1 so that channel 0 wins first.
REQ-028 Reset in any state, including mid-MEASURE or mid-REPORT, SHALL discard the transaction without emitting a result.

Configuration
REQ-029 With macro THEE_MEAS_SCHED_ABORT_EN defined, req[sel] low during SETTLE or MEASURE SHALL abort to IDLE on the next edge, with no result; last_grant SHALL become sel.
REQ-030 Without THEE_MEAS_SCHED_ABORT_EN, a dropped req SHALL be ignored and the window SHALL complete and report normally.

Verification
REQ-031 Reset release, req=4'b0001, edge_pulse[0] every 4th cycle, WIN_CYCLES=1024, res_ready=1 -> res_valid 1026 cycles after grant, res_count=256, res_ch=0, res_ovf=0.
REQ-032 req=4'b1111 held across 5 transactions -> grant order 0,1,2,3,0.
REQ-033 CNT_W=8, edge_pulse[sel] constant 1, WIN_CYCLES=1024 -> res_count=255, res_ovf=1.
REQ-034 res_ready=0 for 10 cycles in REPORT -> res_valid and data held stable for 10 cycles; handshake on the 11th; no new grant before the following cycle.
REQ-035 rst pulsed in cycle 500 of MEASURE -> no res_valid; outputs reset; next grant goes to channel 0.
REQ-036 With ABORT_EN, req[2] dropped mid-MEASURE, req=4'b0110 -> return to IDLE, no result, next grant goes to channel 1; without ABORT_EN -> ch2 result reported normally.
